// File: rtl/ts_bus_sequencer.sv
// ts_bus_sequencer: arbitrates CPU port writes and register-stream player pairs onto the
// turbosound BDIR/BC/DI bus as timed phases, restoring chip-select/register latch state.
module ts_bus_sequencer #(
    parameter int PHASE_LEN = 4,
    parameter int GAP_LEN   = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       cpu_wr,
    input  logic       cpu_bc,
    input  logic [7:0] cpu_di,
    output logic       cpu_busy,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic       pl_chip,
    input  logic [7:0] pl_reg,
    input  logic [7:0] pl_data,
    output logic       BDIR,
    output logic       BC,
    output logic [7:0] DO
);

    localparam int            CNT_MAX  = (PHASE_LEN > GAP_LEN) ? PHASE_LEN : GAP_LEN;
    localparam int            CW       = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] PH_LAST  = CW'(PHASE_LEN - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEL, S_ADDR, S_DATA} state_t;

    state_t        state_q, state_d, next_in_seq, first_phase;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gap_q, gap_d;

    // Active sequence: which later phases remain and the bytes they carry
    logic       need_addr_q, need_data_q, seq_cpu_q;
    logic [7:0] sel_q, reg_q, data_q;

    logic       slot_v_q, slot_bc_q;
    logic [7:0] slot_di_q;
    logic [7:0] cpu_sel_q, cpu_reg_q, bus_sel_q, bus_reg_q;
    logic       bus_acc_q, cpu_busy_q;

    logic       accept, acc_is_sel, eff_slot_v, eff_bc;
    logic [7:0] eff_di, cpu_sel_n, cpu_reg_n, bus_sel_n, bus_reg_n;
    logic       bus_acc_n;
    logic       bdir_end, phase_done, seq_end, free_slot;
    logic       start_cpu, start_pl, start, pl_ready_c;
    logic       st_need_sel, st_need_addr, st_need_data;
    logic [7:0] st_sel, st_reg, st_data;
    logic       ph_start;
    logic [7:0] ph_val;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        accept     = cpu_wr & ~cpu_busy_q;
        acc_is_sel = cpu_bc & (cpu_di[7:3] == 5'b11111);
        cpu_sel_n  = (accept && acc_is_sel) ? cpu_di : cpu_sel_q;
        cpu_reg_n  = (accept && cpu_bc && !acc_is_sel) ? cpu_di : cpu_reg_q;
        eff_slot_v = slot_v_q | accept;
        eff_bc     = slot_v_q ? slot_bc_q : cpu_bc;
        eff_di     = slot_v_q ? slot_di_q : cpu_di;

        bdir_end   = (state_q != S_IDLE) && !gap_q && (cnt_q == PH_LAST);
        phase_done = (state_q != S_IDLE) && gap_q && (cnt_q == GAP_LAST);

        next_in_seq = S_IDLE;
        case (state_q)
            S_SEL:   next_in_seq = need_addr_q ? S_ADDR : (need_data_q ? S_DATA : S_IDLE);
            S_ADDR:  next_in_seq = need_data_q ? S_DATA : S_IDLE;
            default: next_in_seq = S_IDLE;
        endcase

        seq_end    = phase_done && (next_in_seq == S_IDLE);
        free_slot  = (state_q == S_IDLE) || seq_end;
        start_cpu  = free_slot && eff_slot_v;
        pl_ready_c = (state_q == S_IDLE) && !slot_v_q && !cpu_wr && !RESET;
        start_pl   = pl_valid && pl_ready_c;
        start      = start_cpu || start_pl;

        // Bus latch state as the turbosound will hold it after this edge
        bus_sel_n = bus_sel_q;
        bus_reg_n = bus_reg_q;
        bus_acc_n = bus_acc_q;
        if (phase_done && state_q == S_SEL) begin
            bus_sel_n = DO;
            bus_acc_n = 1'b0;
        end
        if (phase_done && state_q == S_ADDR) begin
            bus_reg_n = DO;
            bus_acc_n = 1'b1;
        end

        st_need_sel  = 1'b0;
        st_need_addr = 1'b0;
        st_need_data = 1'b0;
        st_sel       = cpu_sel_n;
        st_reg       = cpu_reg_n;
        st_data      = eff_di;
        if (start_cpu) begin
            if (eff_bc && eff_di[7:3] == 5'b11111) begin
                st_need_sel = 1'b1;
                st_sel      = eff_di;
            end else if (eff_bc) begin
                st_need_sel  = (bus_sel_n != cpu_sel_n);
                st_need_addr = 1'b1;
                st_reg       = eff_di;
            end else begin
                st_need_sel  = (bus_sel_n != cpu_sel_n);
                st_need_addr = st_need_sel || (bus_reg_n != cpu_reg_n) || !bus_acc_n;
                st_need_data = 1'b1;
            end
        end else if (start_pl) begin
            st_sel       = {cpu_sel_q[7:1], pl_chip};
            st_need_sel  = (bus_sel_n != st_sel);
            st_need_addr = 1'b1;
            st_reg       = pl_reg;
            st_need_data = 1'b1;
            st_data      = pl_data;
        end

        first_phase = st_need_sel ? S_SEL : (st_need_addr ? S_ADDR : S_DATA);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        if (start) begin
            state_d = first_phase;
            cnt_d   = '0;
            gap_d   = 1'b0;
        end else if (phase_done) begin
            state_d = next_in_seq;
            cnt_d   = '0;
            gap_d   = 1'b0;
        end else if (bdir_end) begin
            cnt_d = '0;
            gap_d = 1'b1;
        end else if (state_q != S_IDLE) begin
            cnt_d = cnt_q + CW'(1);
        end

        ph_start = start || (phase_done && next_in_seq != S_IDLE);
        case (state_d)
            S_SEL:   ph_val = start ? st_sel  : sel_q;
            S_ADDR:  ph_val = start ? st_reg  : reg_q;
            default: ph_val = start ? st_data : data_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            need_addr_q <= 1'b0;
            need_data_q <= 1'b0;
            seq_cpu_q   <= 1'b0;
            sel_q       <= 8'h00;
            reg_q       <= 8'h00;
            data_q      <= 8'h00;
            slot_v_q    <= 1'b0;
            slot_bc_q   <= 1'b0;
            slot_di_q   <= 8'h00;
            cpu_sel_q   <= 8'hFF;
            cpu_reg_q   <= 8'h00;
            bus_sel_q   <= 8'hFF;
            bus_reg_q   <= 8'h00;
            bus_acc_q   <= 1'b0;
            cpu_busy_q  <= 1'b0;
            BDIR        <= 1'b0;
            BC          <= 1'b0;
            DO          <= 8'h00;
        end else begin
            if (accept) begin
                if (acc_is_sel)  cpu_sel_q <= cpu_di;
                else if (cpu_bc) cpu_reg_q <= cpu_di;
                slot_bc_q <= cpu_bc;
                slot_di_q <= cpu_di;
            end
            slot_v_q <= eff_slot_v & ~start_cpu;

            if (accept)                     cpu_busy_q <= 1'b1;
            else if (seq_end && seq_cpu_q)  cpu_busy_q <= 1'b0;

            if (start) begin
                need_addr_q <= st_need_addr;
                need_data_q <= st_need_data;
                seq_cpu_q   <= start_cpu;
                sel_q       <= st_sel;
                reg_q       <= st_reg;
                data_q      <= st_data;
            end

            bus_sel_q <= bus_sel_n;
            bus_reg_q <= bus_reg_n;
            bus_acc_q <= bus_acc_n;

            // BC/DO only move at a phase start, so they are stable for the whole BDIR pulse
            if (ph_start) begin
                BDIR <= 1'b1;
                BC   <= (state_d != S_DATA);
                DO   <= ph_val;
            end else if (bdir_end) begin
                BDIR <= 1'b0;
            end
        end
    end

    assign cpu_busy = cpu_busy_q;
    assign pl_ready = pl_ready_c;

endmodule

// File: tb/tb_ts_bus_sequencer.sv
// Directed bench for ts_bus_sequencer: expected {BC,DO} phases are queued as stimulus is driven
// and checked by a bus monitor, along with phase/gap timing and reset behaviour.
module tb_ts_bus_sequencer;

    localparam int P = 4;
    localparam int G = 4;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       cpu_wr, cpu_bc;
    logic [7:0] cpu_di;
    logic       cpu_busy;
    logic       pl_valid, pl_ready, pl_chip;
    logic [7:0] pl_reg, pl_data;
    logic       BDIR, BC;
    logic [7:0] DO;

    int n_checks = 0;
    int n_fail   = 0;
    int rises    = 0;

    logic [8:0] exp_q[$];

    ts_bus_sequencer #(.PHASE_LEN(P), .GAP_LEN(G)) dut (
        .CLK(CLK), .RESET(RESET),
        .cpu_wr(cpu_wr), .cpu_bc(cpu_bc), .cpu_di(cpu_di), .cpu_busy(cpu_busy),
        .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_chip(pl_chip),
        .pl_reg(pl_reg), .pl_data(pl_data),
        .BDIR(BDIR), .BC(BC), .DO(DO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cpu_write(input logic bc, input logic [7:0] di);
        int n = 0;
        while (cpu_busy && n < 200) begin
            tick();
            n++;
        end
        check("cpu_not_busy_timeout", (n < 200), 1);
        cpu_wr = 1'b1;
        cpu_bc = bc;
        cpu_di = di;
        tick();
        cpu_wr = 1'b0;
    endtask

    task automatic pl_send(input logic chip, input logic [7:0] r, input logic [7:0] d);
        int  n  = 0;
        logic hs = 1'b0;
        pl_valid = 1'b1;
        pl_chip  = chip;
        pl_reg   = r;
        pl_data  = d;
        while (!hs && n < 200) begin
            hs = pl_ready;
            tick();
            n++;
        end
        pl_valid = 1'b0;
        check("pl_handshake", hs, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(pl_ready && !BDIR) && n < 300) begin
            tick();
            n++;
        end
        check("idle_timeout", (n < 300), 1);
    endtask

    // Bus monitor: every BDIR pulse must match the next queued phase, last P cycles,
    // keep BC/DO stable, and follow at least G idle cycles after the previous pulse.
    logic [8:0] cap;
    logic       prev_bdir = 1'b0;
    logic       seen_fall = 1'b0;
    int         hi_len = 0;
    int         lo_len = 0;

    always @(negedge CLK) begin
        if (RESET) begin
            prev_bdir = 1'b0;
            seen_fall = 1'b0;
            hi_len    = 0;
            lo_len    = 0;
        end else begin
            if (BDIR && !prev_bdir) begin
                rises++;
                if (seen_fall) check("gap_len_min", (lo_len >= G), 1);
                check("phase_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("phase_bc_do", {BC, DO}, exp_q.pop_front());
                cap    = {BC, DO};
                hi_len = 1;
            end else if (BDIR) begin
                hi_len++;
                check("bc_do_stable", {BC, DO}, cap);
            end
            if (!BDIR && prev_bdir) begin
                check("phase_len", hi_len, P);
                seen_fall = 1'b1;
                lo_len    = 1;
            end else if (!BDIR) begin
                lo_len++;
            end
            prev_bdir = BDIR;
        end
    end

    initial begin
        int cyc;
        int r0;
        RESET    = 1'b1;
        cpu_wr   = 1'b0;
        cpu_bc   = 1'b0;
        cpu_di   = 8'h00;
        pl_valid = 1'b0;
        pl_chip  = 1'b0;
        pl_reg   = 8'h00;
        pl_data  = 8'h00;
        repeat (3) tick();
        check("rst_bdir", BDIR, 0);
        check("rst_bc", BC, 0);
        check("rst_do", DO, 8'h00);
        check("rst_busy", cpu_busy, 0);
        check("rst_pl_ready", pl_ready, 0);
        RESET = 1'b0;
        tick();
        check("idle_pl_ready", pl_ready, 1);

        // Single ADDR phase with exact latency
        exp_q.push_back({1'b1, 8'h07});
        cpu_wr = 1'b1; cpu_bc = 1'b1; cpu_di = 8'h07;
        tick();
        cpu_wr = 1'b0;
        check("lat_c1_bdir", BDIR, 1);
        check("lat_c1_busy", cpu_busy, 1);
        check("lat_c1_do", {BC, DO}, {1'b1, 8'h07});
        repeat (3) tick();
        check("lat_c4_bdir", BDIR, 1);
        tick();
        check("lat_c5_bdir", BDIR, 0);
        check("lat_c5_do_held", {BC, DO}, {1'b1, 8'h07});
        repeat (3) tick();
        check("lat_c8_busy", cpu_busy, 1);
        tick();
        check("lat_c9_busy", cpu_busy, 0);
        wait_idle();

        // Data write: register latch already matches, so a lone DATA phase
        exp_q.push_back({1'b0, 8'h38});
        cpu_write(1'b0, 8'h38);
        wait_idle();

        // Player pair on chip0 needs a select, address and data phase
        exp_q.push_back({1'b1, 8'hFE});
        exp_q.push_back({1'b1, 8'h28});
        exp_q.push_back({1'b0, 8'hF1});
        pl_send(1'b0, 8'h28, 8'hF1);
        cyc = 1;
        while (!pl_ready && cyc < 100) begin
            tick();
            cyc++;
        end
        check("pl_seq_len", cyc, 3 * (P + G) + 1);

        // CPU data write restores chip1 select and R7 before the data
        exp_q.push_back({1'b1, 8'hFF});
        exp_q.push_back({1'b1, 8'h07});
        exp_q.push_back({1'b0, 8'h55});
        cpu_write(1'b0, 8'h55);
        wait_idle();

        // Simultaneous CPU write and player pair: CPU first
        exp_q.push_back({1'b0, 8'hAA});
        exp_q.push_back({1'b1, 8'h08});
        exp_q.push_back({1'b0, 8'h0F});
        cpu_wr = 1'b1; cpu_bc = 1'b0; cpu_di = 8'hAA;
        pl_valid = 1'b1; pl_chip = 1'b1; pl_reg = 8'h08; pl_data = 8'h0F;
        #1;
        check("arb_pl_ready_low", pl_ready, 0);
        tick();
        cpu_wr = 1'b0;
        check("arb_cpu_busy", cpu_busy, 1);
        pl_send(1'b1, 8'h08, 8'h0F);
        wait_idle();

        // Register latch moved by the player: restore R7
        exp_q.push_back({1'b1, 8'h07});
        exp_q.push_back({1'b0, 8'h11});
        cpu_write(1'b0, 8'h11);
        wait_idle();

        // CPU write during a player sequence waits in the slot
        exp_q.push_back({1'b1, 8'hFE});
        exp_q.push_back({1'b1, 8'h01});
        exp_q.push_back({1'b0, 8'h02});
        exp_q.push_back({1'b1, 8'hFF});
        exp_q.push_back({1'b1, 8'h0E});
        pl_send(1'b0, 8'h01, 8'h02);
        repeat (10) tick();
        check("mid_pl_not_busy", cpu_busy, 0);
        cpu_wr = 1'b1; cpu_bc = 1'b1; cpu_di = 8'h0E;
        tick();
        cpu_wr = 1'b0;
        check("slot_busy", cpu_busy, 1);
        wait_idle();

        // Select byte, then a data write that must re-address after the select
        exp_q.push_back({1'b1, 8'hFE});
        cpu_write(1'b1, 8'hFE);
        wait_idle();
        exp_q.push_back({1'b1, 8'h0E});
        exp_q.push_back({1'b0, 8'h33});
        cpu_write(1'b0, 8'h33);
        wait_idle();

        // Reset in the second cycle of a DATA phase
        exp_q.push_back({1'b0, 8'h77});
        cpu_write(1'b0, 8'h77);
        tick();
        RESET = 1'b1;
        tick();
        check("abort_bdir", BDIR, 0);
        check("abort_busy", cpu_busy, 0);
        check("abort_do", {BC, DO}, 9'h000);
        RESET = 1'b0;
        r0 = rises;
        repeat (20) tick();
        check("abort_no_phases", rises, r0);

        // Shadows and bus tracking back at reset values: lone ADDR
        exp_q.push_back({1'b1, 8'h07});
        cpu_write(1'b1, 8'h07);
        wait_idle();

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
